// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
//   Groups the completion-request / CDB-grant signals between the functional
//   unit output latches (master) and the CDB arbiter (slave).
//
//   Handshake: req[i] is a level request from FU i. gnt[i] answers it in the
//   same cycle and the transfer happens at the next posedge. A requester with
//   req[i]=1 and gnt[i]=0 sees stall[i]=1 and must keep its result and req[i]
//   asserted into the next cycle. Nothing moves while en=0 or flush=1.
//
//   Signals
//     en        master->slave  arbitration enable
//     flush     master->slave  clear arbiter age state
//     req       master->slave  per-FU completion request
//     gnt       slave->master  per-FU grant
//     cdb_valid slave->master  per-port valid
//     cdb_idx   slave->master  per-port FU index, slice k = [k*IDX_W +: IDX_W]
//     stall     slave->master  req & ~gnt
// ---------------------------------------------------------------------------
interface cdb_arbiter_if #(
   parameter int NUM_FU  = 8,
   parameter int NUM_CDB = 2,
   parameter int IDX_W   = $clog2(NUM_FU)
);
   logic                     en;
   logic                     flush;
   logic [NUM_FU-1:0]        req;
   logic [NUM_FU-1:0]        gnt;
   logic [NUM_CDB-1:0]       cdb_valid;
   logic [NUM_CDB*IDX_W-1:0] cdb_idx;
   logic [NUM_FU-1:0]        stall;

   modport master (
      output en, flush, req,
      input  gnt, cdb_valid, cdb_idx, stall
   );

   modport slave (
      input  en, flush, req,
      output gnt, cdb_valid, cdb_idx, stall
   );
endinterface

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Grants up to NUM_CDB functional-unit completion requests per cycle onto
//   the common data bus ports. Fixed order is highest FU index first; any
//   requester that has waited STARVE_LIM cycles is promoted above that order.
//   Losers are stalled and must hold their result.
//
//   Ports
//     clock    system clock, all state updates on posedge
//     reset_n  synchronous active-low reset
//     bus      cdb_arbiter_if.slave (en, flush, req in; gnt, cdb_valid,
//              cdb_idx, stall out)
//
//   State is only the per-FU saturating age counter age_q.
// ---------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int NUM_FU     = 8,
   parameter int NUM_CDB    = 2,
   parameter int STARVE_LIM = 3,
   localparam int IDX_W     = $clog2(NUM_FU),
   localparam int CNT_W     = $clog2(STARVE_LIM + 1)
) (
   input  logic          clock,
   input  logic          reset_n,
   cdb_arbiter_if.slave  bus
);

   localparam logic [CNT_W-1:0] AGE_MAX = CNT_W'(STARVE_LIM);

   logic [CNT_W-1:0]         age_q [NUM_FU];
   logic [CNT_W-1:0]         age_d [NUM_FU];

   logic                     active;
   logic [NUM_FU-1:0]        starved;
   logic [NUM_FU-1:0]        gnt_c;
   logic [NUM_CDB-1:0]       cdb_valid_c;
   logic [NUM_CDB*IDX_W-1:0] cdb_idx_c;
   int                       port_n;

   // Reset is folded in here so outputs are already quiet during the reset
   // cycle, not only after the first edge.
   assign active = bus.en & ~bus.flush & reset_n;

   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         starved[i] = bus.req[i] & (age_q[i] == AGE_MAX);
      end
   end

   // Two scans over the FUs, highest index first: pass 0 takes starved
   // requesters, pass 1 takes the rest. port_n counts ports already filled
   // so winners land on CDB0, CDB1, ... in the order they are found.
   always_comb begin
      gnt_c       = '0;
      cdb_valid_c = '0;
      cdb_idx_c   = '0;
      port_n      = 0;
      if (active) begin
         for (int pass = 0; pass < 2; pass++) begin
            for (int i = NUM_FU - 1; i >= 0; i--) begin
               if (bus.req[i] && (starved[i] == (pass == 0)) && (port_n < NUM_CDB)) begin
                  gnt_c[i] = 1'b1;
                  for (int k = 0; k < NUM_CDB; k++) begin
                     if (k == port_n) begin
                        cdb_valid_c[k]                 = 1'b1;
                        cdb_idx_c[k*IDX_W +: IDX_W]    = IDX_W'(i);
                     end
                  end
                  port_n = port_n + 1;
               end
            end
         end
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.cdb_valid = cdb_valid_c;
   assign bus.cdb_idx   = cdb_idx_c;
   assign bus.stall     = active ? (bus.req & ~gnt_c) : '0;

   // Age next-state. flush beats en=0; a granted or idle FU restarts at 0;
   // a stalled FU counts up and sticks at STARVE_LIM.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         age_d[i] = age_q[i];
         if (bus.flush) begin
            age_d[i] = '0;
         end else if (bus.en) begin
            if (gnt_c[i] || !bus.req[i]) begin
               age_d[i] = '0;
            end else if (age_q[i] != AGE_MAX) begin
               age_d[i] = age_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_FU; i++) begin
            age_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            age_q[i] <= age_d[i];
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//   Bench for cdb_arbiter (NUM_FU=8, NUM_CDB=2, STARVE_LIM=3). A reference
//   model of the age counters and grant rule is checked against every output
//   each cycle; directed sequences pin literal grant values.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

   localparam int NUM_FU     = 8;
   localparam int NUM_CDB    = 2;
   localparam int STARVE_LIM = 3;
   localparam int IDX_W      = 3;

   // ---------------- clock / reset ----------------
   logic clock;
   logic reset_n;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   cdb_arbiter_if #(.NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB)) bus ();

   cdb_arbiter #(
      .NUM_FU     (NUM_FU),
      .NUM_CDB    (NUM_CDB),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int                   m_age [NUM_FU];
   logic [NUM_FU-1:0]    m_stall;
   logic [NUM_FU-1:0]    e_gnt;
   logic [NUM_CDB-1:0]   e_valid;
   logic [NUM_CDB*IDX_W-1:0] e_idx;
   logic [NUM_FU-1:0]    e_stall;
   int                   winners[$];

   initial begin
      for (int i = 0; i < NUM_FU; i++) m_age[i] = 0;
      m_stall = '0;
   end

   // Inputs change just after posedge, so at negedge they are the inputs of
   // the cycle that the coming posedge closes.
   always @(negedge clock) begin
      e_gnt   = '0;
      e_valid = '0;
      e_idx   = '0;
      winners.delete();
      if (reset_n && bus.en && !bus.flush) begin
         for (int i = NUM_FU - 1; i >= 0; i--)
            if (bus.req[i] && m_age[i] == STARVE_LIM) winners.push_back(i);
         for (int i = NUM_FU - 1; i >= 0; i--)
            if (bus.req[i] && m_age[i] != STARVE_LIM) winners.push_back(i);
         for (int k = 0; k < NUM_CDB && k < winners.size(); k++) begin
            e_gnt[winners[k]]          = 1'b1;
            e_valid[k]                 = 1'b1;
            e_idx[k*IDX_W +: IDX_W]    = winners[k][IDX_W-1:0];
         end
         e_stall = bus.req & ~e_gnt;
      end else begin
         e_stall = '0;
      end
      chk("gnt",       32'(bus.gnt),       32'(e_gnt));
      chk("cdb_valid", 32'(bus.cdb_valid), 32'(e_valid));
      chk("cdb_idx",   32'(bus.cdb_idx),   32'(e_idx));
      chk("stall",     32'(bus.stall),     32'(e_stall));
      m_stall = e_stall;
      // age bookkeeping for the coming edge
      if (!reset_n || bus.flush) begin
         for (int i = 0; i < NUM_FU; i++) m_age[i] = 0;
      end else if (bus.en) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (e_gnt[i] || !bus.req[i]) m_age[i] = 0;
            else if (m_age[i] < STARVE_LIM) m_age[i] = m_age[i] + 1;
         end
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic [7:0] r, input logic e, input logic f, input logic rn);
      @(posedge clock);
      #1;
      bus.req = r;
      bus.en  = e;
      bus.flush = f;
      reset_n = rn;
   endtask

   task automatic saturate();
      step(8'h00, 1, 0, 1);
      step(8'hFF, 1, 0, 1);
      step(8'hFF, 1, 0, 1);
      step(8'hFF, 1, 0, 1);
   endtask

   task automatic lit_gnt(input string name, input logic [7:0] g);
      @(negedge clock);
      chk(name, 32'(bus.gnt), 32'(g));
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] r;
   initial begin
      reset_n   = 1'b0;
      bus.req   = '0;
      bus.en    = 1'b1;
      bus.flush = 1'b0;
      step(8'hFF, 1, 0, 0);
      @(negedge clock);
      chk("reset_gnt",   32'(bus.gnt), 0);
      chk("reset_stall", 32'(bus.stall), 0);
      step(8'h00, 1, 0, 0);

      // first FF cycle after reset
      step(8'hFF, 1, 0, 1);
      @(negedge clock);
      chk("ff_gnt",   32'(bus.gnt), 32'h C0);
      chk("ff_idx",   32'(bus.cdb_idx), 32'h37);
      chk("ff_valid", 32'(bus.cdb_valid), 32'h3);
      chk("ff_stall", 32'(bus.stall), 32'h3F);
      @(posedge clock); #2;
      for (int i = 0; i < NUM_FU; i++)
         chk("model_age", 32'(m_age[i]), (i < 6) ? 1 : 0);

      // hold FF for five cycles from cleared ages
      step(8'h00, 1, 0, 1);
      exp_q.push_back(8'hC0); exp_q.push_back(8'hC0); exp_q.push_back(8'hC0);
      exp_q.push_back(8'h30); exp_q.push_back(8'h0C);
      for (int c = 0; c < 5; c++) begin
         step(8'hFF, 1, 0, 1);
         lit_gnt("hold_gnt", exp_q.pop_front());
         if (c == 3) chk("hold_idx3", 32'(bus.cdb_idx), 32'h25);
         if (c == 4) chk("hold_idx4", 32'(bus.cdb_idx), 32'h13);
      end

      // starved FU1 beats FU7 for CDB0
      saturate();
      step(8'h82, 1, 0, 1);
      lit_gnt("mixed_gnt", 8'h82);
      chk("mixed_idx", 32'(bus.cdb_idx), 32'h39);

      // enable gating from ages at 2
      step(8'h00, 1, 0, 1);
      step(8'hFF, 1, 0, 1);
      step(8'hFF, 1, 0, 1);
      step(8'hFF, 0, 0, 1);
      lit_gnt("en0_gnt_a", 8'h00);
      step(8'hFF, 0, 0, 1);
      lit_gnt("en0_gnt_b", 8'h00);
      step(8'hFF, 1, 0, 1);
      lit_gnt("en1_gnt_a", 8'hC0);
      step(8'hFF, 1, 0, 1);
      lit_gnt("en1_gnt_b", 8'h30);

      // flush while saturated
      saturate();
      step(8'hFF, 1, 1, 1);
      lit_gnt("flush_gnt", 8'h00);
      chk("flush_stall", 32'(bus.stall), 0);
      step(8'hFF, 1, 0, 1);
      lit_gnt("post_flush_gnt", 8'hC0);

      // flush with en=0: flush still clears
      saturate();
      step(8'hFF, 0, 1, 1);
      lit_gnt("flush_en0_gnt", 8'h00);
      step(8'hFF, 1, 0, 1);
      lit_gnt("post_flush_en0_gnt", 8'hC0);

      // single requester
      step(8'h00, 1, 0, 1);
      for (int c = 0; c < 4; c++) begin
         step(8'h01, 1, 0, 1);
         lit_gnt("single_gnt", 8'h01);
         chk("single_valid", 32'(bus.cdb_valid), 32'h1);
         chk("single_idx",   32'(bus.cdb_idx), 0);
      end

      // one-cycle reset mid-stream
      saturate();
      step(8'hFF, 1, 0, 0);
      lit_gnt("midreset_gnt", 8'h00);
      step(8'hFF, 1, 0, 1);
      lit_gnt("post_midreset_gnt", 8'hC0);

      // random traffic; stalled FUs usually keep requesting
      for (int c = 0; c < 500; c++) begin
         r = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 1) == 1) r = r | 8'($urandom_range(0, 255));
         if ($urandom_range(0, 9) < 8) r = r | m_stall;
         step(r, ($urandom_range(0, 9) != 0), ($urandom_range(0, 24) == 0),
              ($urandom_range(0, 39) != 0));
      end
      step(8'h00, 1, 0, 1);
      @(negedge clock);
      @(posedge clock);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the common data bus (CDB) broadcast ports among functional-unit completion requests in the R10K back end. It grants up to NUM_CDB requesters per cycle using highest-index-first priority, the same ordering as the existing priority selector. Per-requester age counters escalate long-waiting units above that fixed order to prevent starvation. It sits between the FU output latches and the CDB drivers; losers are told to stall and hold their result.

## Interface
- NUM_FU, 8, number of requesting functional units
- NUM_CDB, 2, number of CDB broadcast ports, 1 ≤ NUM_CDB ≤ NUM_FU
- STARVE_LIM, 3, wait cycles after which a requester is "starved", ≥ 1
- IDX_W, $clog2(NUM_FU), width of an FU index
- CNT_W, $clog2(STARVE_LIM+1), age counter width
- clock  in  1  system clock; all state updates on posedge
- reset_n  in  1  synchronous, active-low reset
- en  in  1  arbitration enable; 0 = no grants, state frozen
- flush  in  1  synchronous clear of age state (branch mispredict recovery)
- req  in  NUM_FU  completion request, bit i = FU i holds a result
- gnt  out  NUM_FU  grant vector, popcount ≤ NUM_CDB
- cdb_valid  out  NUM_CDB  port k carries a granted FU this cycle
- cdb_idx  out  NUM_CDB*IDX_W  FU index driving port k (slice k = [k*IDX_W +: IDX_W]); 0 when invalid
- stall  out  NUM_FU  req & ~gnt; FU must hold its result and req next cycle

## Operation
- State: one saturating age counter age[i] (CNT_W bits) per FU. There is no other state.
- starved[i] = req[i] & (age[i] == STARVE_LIM).
- Selection is combinational from req, age, en, flush, and reset_n:
  - Pass 1 grants starved requesters, highest index first, until NUM_CDB ports are used.
  - Pass 2 grants the remaining non-starved requesters, highest index first, into the leftover ports.
  - Ports fill in ascending order. CDB0 takes the first winner of pass 1, or of pass 2 if pass 1 granted none. CDB1 takes the next winner, and so on.
  - Unused ports have cdb_valid=0 and cdb_idx=0.
- gnt, cdb_valid, cdb_idx, and stall are forced to 0 when en=0, flush=1, or reset_n=0.
- Age update at posedge, in priority order:
  - reset_n=0 or flush=1: all age ← 0.
  - en=0: all age hold.
  - gnt[i]=1 or req[i]=0: age[i] ← 0.
  - Otherwise (req[i]=1, gnt[i]=0): age[i] ← min(age[i]+1, STARVE_LIM). The counter saturates and never wraps.
- When more than NUM_CDB requesters are starved, the higher indices win. The lower starved ones stay saturated and win in later cycles.
- A requester dropping req while stalled is a protocol violation. The arbiter simply clears its age.

## Timing
- Grant latency is 0 cycles: gnt is valid in the same cycle as req and is sampled by the CDB drivers at the next posedge.
- Age changes take effect on the grant one cycle after the edge that updates them.
- Reset values: every age = 0. While reset_n=0, all outputs are 0.
- Deasserting reset_n mid-operation for one cycle behaves identically to flush.
- flush and en=0 in the same cycle: flush wins (ages clear).
- req=0: all outputs 0, ages clear.
- NUM_CDB ≥ popcount(req): every requester is granted and stall=0.

## Test plan
(NUM_FU=8, NUM_CDB=2, STARVE_LIM=3)
- Reset, then req=8'hFF for one cycle:
  - Response: gnt=8'hC0, cdb_idx={6,7} (CDB1=6, CDB0=7), stall=8'h3F.
  - Next ages: FU0..5 = 1, FU6..7 = 0.
- Hold req=8'hFF for cycles 0..4:
  - Cycles 0–2: gnt=8'hC0.
  - Cycle 3: gnt=8'h30, CDB0=5, CDB1=4 (starved).
  - Cycle 4: gnt=8'h0C, CDB0=3, CDB1=2.
- Mixed starved/non-starved case: age[1]=3, req=8'h82:
  - Response: CDB0=1 (starved), CDB1=7, gnt=8'h82.
- Enable gating: en=0 with req=8'hFF for 2 cycles, starting with ages at 2 for FU0..5:
  - During en=0: gnt=0, ages unchanged.
  - After en returns to 1: next cycle gnt=8'h30, since ages reach 3 only after one more stalled cycle. Check the intermediate cycle gnt=8'hC0 first.
- flush pulse while ages are saturated, followed by req=8'hFF:
  - Flush cycle: outputs 0.
  - Next cycle: gnt=8'hC0 (ages cleared).
- Single requester req=8'h01 every cycle:
  - Response: gnt=8'h01, CDB0=0, cdb_valid=2'b01, age stays 0.
- Mid-operation reset: reset_n=0 for one cycle mid-stream:
  - Response: identical to the flush case.
